// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Contents: default reset PC, ISA word size, fetch FSM state encoding and a
// helper that sizes occupancy counters for a given queue depth.
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFlush = 1'b1
    } fetch_state_e;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit signals: redirect input, instruction memory
// request/response channel and the decode-facing fetch channel.
//   master : the fetch unit (drives imem request and fetch outputs)
//   slave  : the environment (core pipeline + instruction memory)
interface instr_fetch_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, fetch_ready,
        output imem_req_valid, imem_req_addr,
        output fetch_valid, fetch_instr, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, fetch_ready,
        input  imem_req_valid, imem_req_addr,
        input  fetch_valid, fetch_instr, fetch_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO used for both the fetched-instruction queue and the
// in-flight PC tracker.
// Ports: clk, rst (sync, active-high), flush_i (empties the queue and
// overrides push/pop), push_i/push_data_i, pop_i, head_o (zero when empty),
// count_o (current occupancy).
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32,
    localparam int unsigned CntW = cnt_width(Depth),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CntW'(Depth)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_d - CntW'(1);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches from the PC, tracks
// in-flight request PCs, queues returned instructions for decode and
// discards stale responses after a redirect.
// Ports: clk, rst (sync, active-high), bus (instr_fetch_if.master) carrying
// redirect, imem request/response and decode fetch channels.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int unsigned CntW = cnt_width(QDEPTH);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] out_q, out_d;

    logic            redirect;
    logic            fetch_valid, pop_fire;
    logic            req_valid, req_fire;
    logic            rsp_ok, rsp_keep;
    logic [31:0]     credit_used;

    logic [63:0]     q_head;
    logic [CntW-1:0] q_count;
    logic [31:0]     trk_head;
    logic [CntW-1:0] trk_count;

    logic            unused_trk_count;
    logic            unused_redirect_lsb;
    assign unused_trk_count    = ^trk_count;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        redirect    = !rst && bus.redirect_valid;
        fetch_valid = !rst && (state_q == StRun) && !redirect && (q_count != '0);
        pop_fire    = fetch_valid && bus.fetch_ready;
        // A slot freed by this cycle's pop is immediately reusable, which is
        // what lets the unit sustain one fetch per cycle.
        credit_used = 32'(out_q) + 32'(q_count) - 32'(pop_fire);
        req_valid   = !rst && (state_q == StRun) && !redirect && (credit_used < QDEPTH);
        req_fire    = req_valid && bus.imem_req_ready;
        // Responses with nothing outstanding are protocol errors; drop them.
        rsp_ok      = !rst && bus.imem_rsp_valid && (out_q != '0);
        rsp_keep    = rsp_ok && (state_q == StRun) && !redirect;
    end

    always_comb begin
        pc_d    = pc_q;
        out_d   = out_q;
        state_d = state_q;
        if (redirect) begin
            pc_d = {bus.redirect_pc[31:2], 2'b00};
            if (rsp_ok) out_d = out_q - CntW'(1);
            state_d = (out_d != '0) ? StFlush : StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (req_fire) begin
                        pc_d  = pc_q + 32'(WORD_BYTES);
                        out_d = out_d + CntW'(1);
                    end
                    if (rsp_ok) out_d = out_d - CntW'(1);
                end
                StFlush: begin
                    if (rsp_ok) out_d = out_q - CntW'(1);
                    if (out_d == '0) state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    fetch_queue #(
        .Depth (QDEPTH),
        .Width (64)
    ) u_instr_q (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (rsp_keep),
        .push_data_i ({bus.imem_rsp_data, trk_head}),
        .pop_i       (pop_fire),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    fetch_queue #(
        .Depth (QDEPTH),
        .Width (32)
    ) u_pc_trk (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (rsp_keep),
        .head_o      (trk_head),
        .count_o     (trk_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.fetch_valid    = fetch_valid;
    assign bus.fetch_instr    = fetch_valid ? q_head[63:32] : '0;
    assign bus.fetch_pc       = fetch_valid ? q_head[31:0] : '0;

endmodule
